// File: rtl/decoder_pipe.sv
// -----------------------------------------------------------------------------
// decoder_pipe
//   Turns an SEL_W-bit code into a 2**SEL_W-bit word, with one registered
//   output stage. Valid/ready handshakes sit on both sides. It drives the
//   register-file write select and the bank select.
//
//   Decode modes (in_mode):
//     0  one-hot
//     1  thermometer
//     2  active-low one-hot
//     3  illegal: the word is zero and the sticky err flag is set
//   in_en = 0 gives an inactive word, which is all ones in mode 2.
//   ZERO_MASK = 1 keeps code 0 from ever driving its bit active.
//
//   The output register plus one skid register form a 2-entry buffer. This
//   keeps full throughput under backpressure. in_ready comes straight from a
//   register.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   input entry valid
//   in_ready   block can accept an entry
//   in_sel     code to decode
//   in_en      decode enable
//   in_mode    decode mode (see above)
//   out_valid  output entry valid
//   out_ready  consumer accepts
//   out_dec    decoded word
//   out_sel    echo of in_sel for the entry
//   err        sticky illegal-mode flag
//   err_clr    clears err (a set on the same edge wins)
// -----------------------------------------------------------------------------
module decoder_pipe #(
  parameter int SEL_W     = 2,
  parameter bit ZERO_MASK = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_en,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**SEL_W-1:0]   out_dec,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int OUT_W = 2**SEL_W;

  logic [OUT_W-1:0] w_onehot;
  logic [OUT_W-1:0] w_therm;
  logic [OUT_W-1:0] w_dec;
  logic             w_accept;
  logic             w_pop;
  logic             w_out_load;
  logic             w_skid_valid_nxt;

  logic             r_in_ready;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_dec;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_dec;
  logic [SEL_W-1:0] r_skid_sel;
  logic             r_err;

  // Decode the incoming entry. The word is stored already decoded.
  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_onehot         = '0;
    w_onehot[in_sel] = 1'b1;
    // (onehot << 1) - 1 sets bits 0..k. For k = OUT_W-1 the shift wraps to
    // zero, and zero minus one is all ones, which is the required result.
    w_therm = (w_onehot << 1) - OUT_W'(1);

    case (in_mode)
      2'd0:    w_dec = w_onehot;
      2'd1:    w_dec = w_therm;
      2'd2:    w_dec = ~w_onehot;
      default: w_dec = '0;
    endcase

    if (!in_en) begin
      w_dec = (in_mode == 2'd2) ? '1 : '0;
    end

    // Hard-wired zero register: bit 0 is always left at its inactive level.
    if (ZERO_MASK) begin
      w_dec[0] = (in_mode == 2'd2);
    end
  end

  assign w_accept   = in_valid & r_in_ready;
  assign w_pop      = r_out_valid & out_ready;
  assign w_out_load = ~r_out_valid | w_pop;
  // When the output slot frees up, the skid entry moves into it (or the skid
  // stays empty). Otherwise an accepted entry lands in the skid.
  assign w_skid_valid_nxt = w_out_load ? 1'b0 : (r_skid_valid | w_accept);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_dec    <= '0;
      r_out_sel    <= '0;
      r_skid_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_in_ready   <= ~w_skid_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;

      if (w_out_load) begin
        if (r_skid_valid) begin
          r_out_valid <= 1'b1;
          r_out_dec   <= r_skid_dec;
          r_out_sel   <= r_skid_sel;
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out_dec   <= w_dec;
          r_out_sel   <= in_sel;
        end else begin
          r_out_valid <= 1'b0;
        end
      end

      if (w_accept && in_mode == 2'd3) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // NOTE: the skid payload has no reset. It is only read while r_skid_valid
  // is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (w_accept && !w_out_load) begin
      r_skid_dec <= w_dec;
      r_skid_sel <= in_sel;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_dec   = r_out_dec;
  assign out_sel   = r_out_sel;
  assign err       = r_err;

endmodule

// File: tb/tb_decoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_decoder_pipe
//   Three instances share one stimulus stream:
//     u_a  SEL_W=2, ZERO_MASK=0
//     u_b  SEL_W=3, ZERO_MASK=0
//     u_c  SEL_W=2, ZERO_MASK=1
//   Accepted entries go into a scoreboard queue, each with the expected word
//   for every instance. A negedge monitor checks the handshake, the head
//   entry and err, and pops the queue when the consumer accepts.
// -----------------------------------------------------------------------------
module tb_decoder_pipe;

  typedef struct {
    logic [3:0] dec_a;
    logic [7:0] dec_b;
    logic [3:0] dec_c;
    logic [2:0] sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_sel = '0;
  logic       in_en = 1'b0;
  logic [1:0] in_mode = '0;
  logic       out_ready = 1'b1;
  logic       err_clr = 1'b0;

  logic       rdy_a, ov_a, err_a;
  logic [3:0] dec_a;
  logic [1:0] sel_a;
  logic       rdy_b, ov_b, err_b;
  logic [7:0] dec_b;
  logic [2:0] sel_b;
  logic       rdy_c, ov_c, err_c;
  logic [3:0] dec_c;
  logic [1:0] sel_c;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  bit   started = 1'b0;
  bit   armed = 1'b0;
  bit   exp_rdy = 1'b0;
  bit   err_m = 1'b0;

  always #5 clk = ~clk;

  decoder_pipe #(.SEL_W(2), .ZERO_MASK(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_sel(in_sel[1:0]), .in_en(in_en), .in_mode(in_mode),
    .out_valid(ov_a), .out_ready(out_ready), .out_dec(dec_a),
    .out_sel(sel_a), .err(err_a), .err_clr(err_clr));

  decoder_pipe #(.SEL_W(3), .ZERO_MASK(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_sel(in_sel), .in_en(in_en), .in_mode(in_mode),
    .out_valid(ov_b), .out_ready(out_ready), .out_dec(dec_b),
    .out_sel(sel_b), .err(err_b), .err_clr(err_clr));

  decoder_pipe #(.SEL_W(2), .ZERO_MASK(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c),
    .in_sel(in_sel[1:0]), .in_en(in_en), .in_mode(in_mode),
    .out_valid(ov_c), .out_ready(out_ready), .out_dec(dec_c),
    .out_sel(sel_c), .err(err_c), .err_clr(err_clr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // Builds the decoded word bit by bit from the rules: which bit positions
  // are active for code k, then what level "active" means in each mode.
  function automatic logic [7:0] ref_dec(input int sel_w, input bit zm,
                                         input logic [2:0] s, input bit en,
                                         input logic [1:0] m);
    logic [7:0] r = '0;
    int k = int'(s) % (1 << sel_w);
    for (int i = 0; i < (1 << sel_w); i++) begin
      bit act;
      case (m)
        2'd0:    act = (i == k);
        2'd1:    act = (i <= k);
        2'd2:    act = (i == k);
        default: act = 1'b0;
      endcase
      if (!en) act = 1'b0;
      if (zm && i == 0) act = 1'b0;
      r[i] = (m == 2'd2) ? !act : act;
    end
    return r;
  endfunction

  // Accept recorder: looks at the pre-edge inputs on every rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      err_m = 1'b0;
      armed = 1'b0;
    end else begin
      if (in_valid && exp_rdy) begin
        exp_t e;
        e.dec_a = ref_dec(2, 1'b0, in_sel, in_en, in_mode)[3:0];
        e.dec_b = ref_dec(3, 1'b0, in_sel, in_en, in_mode);
        e.dec_c = ref_dec(2, 1'b1, in_sel, in_en, in_mode)[3:0];
        e.sel   = in_sel;
        q.push_back(e);
      end
      if (in_valid && exp_rdy && in_mode == 2'd3) err_m = 1'b1;
      else if (err_clr) err_m = 1'b0;
      armed = 1'b1;
    end
    started = 1'b1;
  end

  // Monitor: samples at the falling edge, half a cycle away from updates.
  always @(negedge clk) begin
    if (started) begin
      exp_rdy = armed && (q.size() < 2);
      check("in_ready_a", 32'(rdy_a), 32'(exp_rdy));
      check("in_ready_b", 32'(rdy_b), 32'(exp_rdy));
      check("in_ready_c", 32'(rdy_c), 32'(exp_rdy));
      check("out_valid_a", 32'(ov_a), 32'(q.size() > 0));
      check("out_valid_b", 32'(ov_b), 32'(q.size() > 0));
      check("out_valid_c", 32'(ov_c), 32'(q.size() > 0));
      check("err_a", 32'(err_a), 32'(err_m));
      check("err_b", 32'(err_b), 32'(err_m));
      check("err_c", 32'(err_c), 32'(err_m));
      if (!armed) begin
        check("reset_dec_b", 32'(dec_b), 32'h0);
        check("reset_sel_b", 32'(sel_b), 32'h0);
      end
      if (q.size() > 0) begin
        check("dec_a", 32'(dec_a), 32'(q[0].dec_a));
        check("dec_b", 32'(dec_b), 32'(q[0].dec_b));
        check("dec_c", 32'(dec_c), 32'(q[0].dec_c));
        check("sel_a", 32'(sel_a), 32'(q[0].sel[1:0]));
        check("sel_b", 32'(sel_b), 32'(q[0].sel));
        check("sel_c", 32'(sel_c), 32'(q[0].sel[1:0]));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input logic [2:0] s, input bit e,
                       input logic [1:0] m, input bit r, input bit c);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_en     = e;
    in_mode   = m;
    out_ready = r;
    err_clr   = c;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(2);
    drive(0, 0, 0, 0, 1, 0);

    // Streaming one-hot at full rate.
    for (int i = 0; i < 4; i++) drive(1, 3'(i), 1, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);

    // Backpressure: both entries are held, then drain in order.
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 2, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 1, 0);

    // Mode coverage, including en=0.
    drive(1, 5, 1, 1, 1, 0);
    drive(1, 5, 1, 2, 1, 0);
    drive(1, 5, 0, 2, 1, 0);
    drive(1, 5, 0, 0, 1, 0);
    // Code-0 masking cases.
    drive(1, 0, 1, 0, 1, 0);
    drive(1, 0, 1, 2, 1, 0);
    drive(1, 2, 1, 1, 1, 0);
    drive(1, 3, 1, 1, 1, 0);

    // Illegal mode: a set beats a same-edge clear; a clear alone clears.
    drive(1, 2, 1, 3, 1, 0);
    drive(1, 1, 0, 3, 1, 1);
    drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 0);

    // A mode-3 entry that is not accepted leaves err clear.
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 3, 1, 3, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 1, 0);

    // Reset while both entries are buffered.
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 2, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    do_reset(1);
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 3, 1, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 4) != 0,
            2'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
    end

    repeat (4) drive(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
